// File: rtl/isdu_control.sv
// rtl/isdu_control.sv - LC-3 subset fetch/decode/execute sequencer
module isdu_control #(
    parameter int unsigned MEM_WAIT = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    typedef enum logic [4:0] {
        HALTED, S_18, MR_FETCH, S_35, S_32, S_01, S_05, S_09, S_00, S_22,
        S_12, S_04, S_21, S_06, MR_LDR, S_27, S_07, S_23, M_W,
        PAUSE_IR1, PAUSE_IR2
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       mem_last;

    // JSRR is not supported, so IR[11] has no effect on sequencing.
    logic unused_ir11;
    assign unused_ir11 = IR_11;

    assign mem_last = (cnt_q == WAIT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            HALTED:    if (Run) state_d = S_18;
            S_18: begin
                state_d = MR_FETCH;
                cnt_d   = '0;
            end
            MR_FETCH:  if (mem_last) state_d = S_35; else cnt_d = cnt_q + 3'd1;
            S_35:      state_d = S_32;
            S_32: begin
                case (Opcode)
                    4'b0001: state_d = S_01;
                    4'b0101: state_d = S_05;
                    4'b1001: state_d = S_09;
                    4'b0000: state_d = S_00;
                    4'b1100: state_d = S_12;
                    4'b0100: state_d = S_04;
                    4'b0110: state_d = S_06;
                    4'b0111: state_d = S_07;
                    4'b1101: state_d = PAUSE_IR1;
                    default: state_d = S_18;
                endcase
            end
            S_01, S_05, S_09, S_22, S_12, S_21, S_27: state_d = S_18;
            S_00:      state_d = BEN ? S_22 : S_18;
            S_04:      state_d = S_21;
            S_06: begin
                state_d = MR_LDR;
                cnt_d   = '0;
            end
            MR_LDR:    if (mem_last) state_d = S_27; else cnt_d = cnt_q + 3'd1;
            S_07:      state_d = S_23;
            S_23: begin
                state_d = M_W;
                cnt_d   = '0;
            end
            M_W:       if (mem_last) state_d = S_18; else cnt_d = cnt_q + 3'd1;
            PAUSE_IR1: if (Continue) state_d = PAUSE_IR2;
            PAUSE_IR2: if (!Continue) state_d = S_18;
            default:   state_d = HALTED;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= HALTED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore decode of the current state; SR2MUX alone follows IR_5 live.
    always_comb begin
        LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
        LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
        GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
        PCMUX = 2'b00; DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
        ADDR1MUX = 1'b0; ADDR2MUX = 2'b00; ALUK = 2'b00;
        Mem_OE = 1'b1; Mem_WE = 1'b1;
        case (state_q)
            S_18: begin
                GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1;
            end
            MR_FETCH, MR_LDR: begin
                Mem_OE = 1'b0;
                LD_MDR = mem_last;
            end
            S_35: begin
                GateMDR = 1'b1; LD_IR = 1'b1;
            end
            S_32: LD_BEN = 1'b1;
            S_01, S_05, S_09: begin
                SR1MUX = 1'b1; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
                ALUK = (state_q == S_01) ? 2'b00 : (state_q == S_05) ? 2'b01 : 2'b10;
                SR2MUX = (state_q == S_09) ? 1'b0 : IR_5;
            end
            S_22: begin
                ADDR2MUX = 2'b10; PCMUX = 2'b10; LD_PC = 1'b1;
            end
            S_12: begin
                SR1MUX = 1'b1; ADDR1MUX = 1'b1; PCMUX = 2'b10; LD_PC = 1'b1;
            end
            S_04: begin
                GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1;
            end
            S_21: begin
                ADDR2MUX = 2'b11; PCMUX = 2'b10; LD_PC = 1'b1;
            end
            S_06, S_07: begin
                SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01;
                GateMARMUX = 1'b1; LD_MAR = 1'b1;
            end
            S_27: begin
                GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
            end
            S_23: begin
                ALUK = 2'b11; GateALU = 1'b1; LD_MDR = 1'b1;
            end
            M_W:       Mem_WE = 1'b0;
            PAUSE_IR1: LD_LED = 1'b1;
            default: ;
        endcase
    end

endmodule
